// File: rtl/spi_cmd_pkg.sv
// Shared opcodes and FSM state type for the SPI group command sequencer.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_ADDR  = 8'h01;
    localparam logic [7:0] OP_WRITE_PIX = 8'h02;
    localparam logic [7:0] OP_WRITE_REG = 8'h03;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPix,
        StRegval,
        StDrop
    } state_e;

endpackage

// File: rtl/spi_cmd_regfile.sv
// NREG x 16-bit configuration register bank, written by strobe/index/data.
module spi_cmd_regfile #(
    parameter int unsigned NREG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [7:0]         idx,
    input  logic [15:0]        wdat,
    output logic [NREG*16-1:0] cfg
);

    logic [15:0] regs_q [NREG];

    // Out-of-range indices match no entry, so they write nothing.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREG; i++) begin
            if (rst) begin
                regs_q[i] <= 16'd0;
            end else if (we && idx == 8'(i)) begin
                regs_q[i] <= wdat;
            end
        end
    end

    always_comb begin
        cfg = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cfg[16*i +: 16] = regs_q[i];
        end
    end

endmodule

// File: rtl/spi_group_cmd_seq.sv
// Decodes 3-byte SPI groups into pixel writes and config register writes.
// Optional error counter enabled by defining SPI_CMD_SEQ_ERRCNT_EN.
module spi_group_cmd_seq #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned ADDR_LAST = 2**ADDR_W - 1,
    parameter int unsigned NREG      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               css,
    input  logic               groupRdy,
    input  logic [23:0]        outGroupDat,
    output logic               pix_we,
    input  logic               pix_ack,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [23:0]        pix_dat,
    output logic [NREG*16-1:0] cfg,
    output logic               busy,
    output logic               err,
    output logic [7:0]         err_cnt
);
    import spi_cmd_pkg::*;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(ADDR_LAST);

    state_e            state_q, state_d;
    logic              pix_we_q, pix_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       dat_q, dat_d;
    logic [15:0]       count_q, count_d;
    logic [7:0]        idx_q, idx_d;
    logic              err_q, err_d;
    logic              rf_we;
    logic [7:0]        op;

    assign op = outGroupDat[23:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pix_we_q <= 1'b0;
            addr_q   <= '0;
            dat_q    <= 24'd0;
            count_q  <= 16'd0;
            idx_q    <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_we_q <= pix_we_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pix_we_d = pix_we_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        count_d  = count_q;
        idx_d    = idx_q;
        err_d    = 1'b0;
        rf_we    = 1'b0;

        // A pending write retires independently of the frame state.
        if (pix_we_q && pix_ack) begin
            pix_we_d = 1'b0;
            addr_d   = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
        end

        if (!css) begin
            state_d = StIdle;
            count_d = 16'd0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StHdr;
                StHdr: begin
                    if (groupRdy) begin
                        case (op)
                            OP_NOP:      ;
                            OP_SET_ADDR: addr_d = outGroupDat[ADDR_W-1:0];
                            OP_WRITE_PIX: begin
                                count_d = outGroupDat[15:0];
                                if (outGroupDat[15:0] != 16'd0) state_d = StPix;
                            end
                            OP_WRITE_REG: begin
                                idx_d   = outGroupDat[7:0];
                                state_d = StRegval;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = StDrop;
                            end
                        endcase
                    end
                end
                StPix: begin
                    if (groupRdy) begin
                        if (pix_we_q && !pix_ack) begin
                            err_d   = 1'b1;
                            state_d = StDrop;
                        end else begin
                            pix_we_d = 1'b1;
                            dat_d    = outGroupDat;
                            count_d  = count_q - 16'd1;
                            if (count_q == 16'd1) state_d = StHdr;
                        end
                    end
                end
                StRegval: begin
                    if (groupRdy) begin
                        if ({24'd0, idx_q} < NREG) rf_we = 1'b1;
                        else                       err_d = 1'b1;
                        state_d = StHdr;
                    end
                end
                StDrop:  ;
                default: state_d = StIdle;
            endcase
        end
    end

    spi_cmd_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .we   (rf_we),
        .idx  (idx_q),
        .wdat (outGroupDat[15:0]),
        .cfg  (cfg)
    );

`ifdef SPI_CMD_SEQ_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign pix_we   = pix_we_q;
    assign pix_addr = addr_q;
    assign pix_dat  = dat_q;
    assign busy     = (state_q != StIdle);
    assign err      = err_q;

endmodule
